// File: rtl/sized_mem_port_pkg.sv
// ============================================================================
// Module  : sized_mem_pkg
// Brief   : Shared types and helpers for the sized data-memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sized_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        logic [3:0] nbytes;
        case (size)
            SZ_BYTE:  nbytes = 4'd1;
            SZ_HALF:  nbytes = 4'd2;
            SZ_WORD:  nbytes = 4'd4;
            default:  nbytes = 4'd8;
        endcase
        return nbytes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF:  mis = addr_lo[0];
            SZ_WORD:  mis = |addr_lo[1:0];
            SZ_DWORD: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sized_mem_port_if.sv
// ============================================================================
// Module  : sized_mem_port_if
// Brief   : Request/response bus between the load/store unit and the port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sized_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

`default_nettype wire

// File: rtl/sized_mem_port_array.sv
// ============================================================================
// Module  : sized_mem_array
// Brief   : Single-port word array, per-byte write enable, registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sized_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 16
) (
    input  wire logic                  clk,
    input  wire logic [DATA_W/8-1:0]   i_we,
    input  wire logic                  i_re,
    input  wire logic [DEPTH_LOG2-1:0] i_addr,
    input  wire logic [DATA_W-1:0]     i_wdata,
    output logic      [DATA_W-1:0]     o_rdata
);
    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately left unreset so the array maps onto RAM macros.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sized_mem_port.sv
// ============================================================================
// Module  : sized_mem_port
// Brief   : Byte-addressable big-endian load/store port over an inferred array.
//           Optional bounds checking: SIZED_MEM_PORT_BOUNDS_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sized_mem_port
    import sized_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 16,
    parameter int ADDR_W     = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    sized_mem_port_if.slave bus
);
    localparam int         c_NB   = DATA_W / 8;
    localparam int         c_OFS  = $clog2(c_NB);
    localparam int         c_AW   = DEPTH_LOG2 + c_OFS;
    localparam logic [3:0] c_NB4  = 4'(c_NB);

    state_e              r_state;
    logic [c_AW-1:0]     r_addr;
    logic [1:0]          r_size;
    logic                r_write;
    logic                r_signed;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_error;

    logic [ADDR_W-1:0]   w_addr;
    logic                w_accept;
    logic                w_oob;
    logic                w_req_err;
    logic [3:0]          w_nbytes;
    logic [3:0]          w_off;
    logic [3:0]          w_lane_lo;
    logic [c_NB-1:0]     w_lane_en;
    logic [c_NB-1:0]     w_we;
    logic                w_re;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_fill;
    logic [DATA_W-1:0]   w_load_data;

    assign w_addr   = bus.req_addr;
    assign w_accept = bus.req_valid & bus.req_ready;

`ifdef SIZED_MEM_PORT_BOUNDS_CHECK_EN
    assign w_oob = |(w_addr >> c_AW);
`else
    assign w_oob = 1'b0;
`endif

    assign w_req_err = is_misaligned(bus.req_size, w_addr[2:0])
                     | ((bus.req_size == SZ_DWORD) && (DATA_W == 32))
                     | w_oob;

    // Errored requests skip ACCESS entirely so the array is never touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_size      <= 2'd0;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_wdata     <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= w_addr[c_AW-1:0];
                        r_size      <= bus.req_size;
                        r_write     <= bus.req_write;
                        r_signed    <= bus.req_signed;
                        r_wdata     <= bus.req_wdata;
                        r_rsp_error <= w_req_err;
                        if (w_req_err) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_error <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane numbering follows the bit position of the byte; offset 0 is the top lane.
    always_comb begin
        w_nbytes = size_to_bytes(r_size);
        if (w_nbytes > c_NB4) begin
            w_nbytes = c_NB4;
        end
        w_off       = 4'(r_addr[c_OFS-1:0]);
        w_lane_lo   = c_NB4 - w_off - w_nbytes;
        w_lane_en   = '0;
        w_wdata_rep = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_lane_en[i] = (4'(i) >= w_lane_lo) && (4'(i) < (w_lane_lo + w_nbytes));
            w_wdata_rep[8*i +: 8] = r_wdata[8*(i & (int'(w_nbytes) - 1)) +: 8];
        end
    end

    assign w_we = ((r_state == ST_ACCESS) && r_write) ? w_lane_en : '0;
    assign w_re = (r_state == ST_ACCESS) && !r_write;

    sized_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_addr[c_AW-1:c_OFS]),
        .i_wdata (w_wdata_rep),
        .o_rdata (w_rd_data)
    );

    // Right-justify the selected lane, then extend; full-width loads need no fill.
    always_comb begin
        w_shifted = w_rd_data >> {w_lane_lo, 3'b000};
        case (w_nbytes)
            4'd1:    w_fill = r_signed & w_shifted[7];
            4'd2:    w_fill = r_signed & w_shifted[15];
            4'd4:    w_fill = r_signed & w_shifted[31];
            default: w_fill = 1'b0;
        endcase
        w_load_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_load_data[i] = (i < 8 * int'(w_nbytes)) ? w_shifted[i] : w_fill;
        end
    end

    assign bus.req_ready = rst_n && (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_rdata = ((r_state == ST_RESP) && !r_rsp_error && !r_write) ? w_load_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_sized_mem_port.sv
// ============================================================================
// Module  : tb_sized_mem_port
// Brief   : Directed scoreboard bench for sized_mem_port (large and tiny array).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sized_mem_port;
    import sized_mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel      = 1'b0;
    logic          t_valid  = 1'b0;
    logic          t_write  = 1'b0;
    logic [1:0]    t_size   = 2'd0;
    logic          t_signed = 1'b0;
    logic [AW-1:0] t_addr   = '0;
    logic [DW-1:0] t_wdata  = '0;
    logic          t_rready = 1'b1;

    sized_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_l ();
    sized_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

    assign bus_l.req_valid  = t_valid & ~sel;
    assign bus_s.req_valid  = t_valid & sel;
    assign bus_l.req_write  = t_write;
    assign bus_s.req_write  = t_write;
    assign bus_l.req_size   = t_size;
    assign bus_s.req_size   = t_size;
    assign bus_l.req_signed = t_signed;
    assign bus_s.req_signed = t_signed;
    assign bus_l.req_addr   = t_addr;
    assign bus_s.req_addr   = t_addr;
    assign bus_l.req_wdata  = t_wdata;
    assign bus_s.req_wdata  = t_wdata;
    assign bus_l.rsp_ready  = t_rready;
    assign bus_s.rsp_ready  = t_rready;

    sized_mem_port #(.DATA_W(DW), .DEPTH_LOG2(10), .ADDR_W(AW)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    sized_mem_port #(.DATA_W(DW), .DEPTH_LOG2(4), .ADDR_W(AW)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    wire          w_ready = sel ? bus_s.req_ready : bus_l.req_ready;
    wire          w_valid = sel ? bus_s.rsp_valid : bus_l.rsp_valid;
    wire [DW-1:0] w_rdata = sel ? bus_s.rsp_rdata : bus_l.rsp_rdata;
    wire          w_error = sel ? bus_s.rsp_error : bus_l.rsp_error;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request, pushes its expectation, then checks the response
    // against the popped entry; hold > 0 keeps rsp_ready low that many cycles.
    task automatic issue(input string tag, input logic s, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        int   lat;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : 2;
        sb_q.push_back(e);
        @(negedge clk);
        sel      = s;
        t_write  = wr;
        t_size   = sz;
        t_signed = sg;
        t_addr   = a;
        t_wdata  = d;
        t_rready = (hold == 0);
        t_valid  = 1'b1;
        check({tag, "_req_ready"}, 64'(w_ready), 64'(1));
        @(posedge clk);
        #1 t_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!w_valid && lat < 10);
        check({tag, "_timeout"}, 64'(w_valid), 64'(1));
        e = sb_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_rdata"}, 64'(w_rdata), 64'(e.rdata));
        check({tag, "_error"}, 64'(w_error), 64'(e.err));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(w_valid), 64'(1));
            check({tag, "_hold_rdata"}, 64'(w_rdata), 64'(e.rdata));
            check({tag, "_hold_error"}, 64'(w_error), 64'(e.err));
            check({tag, "_hold_ready"}, 64'(w_ready), 64'(0));
        end
        t_rready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_req_ready", 64'(bus_l.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus_l.rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(bus_l.rsp_rdata), 64'(0));
        check("rst_rsp_error", 64'(bus_l.rsp_error), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(bus_l.req_ready), 64'(1));

        issue("st_w",    1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        issue("ld_w",    1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        issue("st_b",    1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h7F, 32'h0, 1'b0, 0);
        issue("ld_w2",   1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDE7FBEEF, 1'b0, 0);
        issue("ld_h_s",  1'b0, 1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
        issue("ld_b_u",  1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h000000EF, 1'b0, 0);
        issue("ld_b_sp", 1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h0000007F, 1'b0, 0);
        issue("ld_b_sn", 1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h100, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
        issue("ld_h_hi", 1'b0, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'hFFFFDE7F, 1'b0, 0);
        issue("ld_h_u",  1'b0, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'h0000BEEF, 1'b0, 0);
        issue("mis_h",   1'b0, 1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 0);
        issue("mis_w",   1'b0, 1'b1, SZ_WORD, 1'b0, 32'h102, 32'h0BADF00D, 32'h0, 1'b1, 0);
        issue("ld_after_mis", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDE7FBEEF, 1'b0, 0);
        issue("dword32", 1'b0, 1'b0, SZ_DWORD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        issue("st_w2",   1'b0, 1'b1, SZ_WORD, 1'b0, 32'h104, 32'h11223344, 32'h0, 1'b0, 0);
        issue("st_h",    1'b0, 1'b1, SZ_HALF, 1'b0, 32'h106, 32'h0000CAFE, 32'h0, 1'b0, 0);
        issue("ld_hold", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'h1122CAFE, 1'b0, 5);

        // Store aborted by reset while in ACCESS; no scoreboard entry as no response is due.
        @(negedge clk);
        sel = 1'b0; t_write = 1'b1; t_size = SZ_WORD; t_signed = 1'b0;
        t_addr = 32'h100; t_wdata = 32'h55667788; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstacc_rsp_valid", 64'(bus_l.rsp_valid), 64'(0));
        check("rstacc_req_ready", 64'(bus_l.req_ready), 64'(0));
        repeat (2) @(negedge clk);
        check("rstacc_rsp_valid2", 64'(bus_l.rsp_valid), 64'(0));
        rst_n = 1'b1;
        issue("ld_after_rst", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDE7FBEEF, 1'b0, 0);

        issue("s_st0", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h00, 32'h12345678, 32'h0, 1'b0, 0);
`ifdef SIZED_MEM_PORT_BOUNDS_CHECK_EN
        issue("s_oob", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 0);
`else
        issue("s_wrap", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 0);
`endif
        issue("s_ld0", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h03, 32'h0, 32'h00000078, 1'b0, 0);

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
